mouse_latch_writer: RTL and testbench

//  Producer side of the Kempston mouse latch bus. Takes decoded PS/2 mouse bytes from the PS/2

---
 rtl/mouse_latch_pkg.sv | 35 +++
 rtl/ps2_mouse_packet.sv | 126 ++++++++++++
 rtl/mouse_latch_writer.sv | 209 ++++++++++++++++++++
 tb/tb_mouse_latch_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_latch_pkg.sv
// Shared types and constants for the Kempston mouse latch writer.
// Optional wheel support is enabled by defining MOUSE_WHEEL_EN.
package mouse_latch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } seq_state_t;

    typedef enum logic [1:0] {
        SEL_X,
        SEL_Y,
        SEL_KEY
    } reg_sel_t;

    localparam int unsigned B0_YOVF  = 7;
    localparam int unsigned B0_XOVF  = 6;
    localparam int unsigned B0_YSIGN = 5;
    localparam int unsigned B0_XSIGN = 4;
    localparam int unsigned B0_SYNC  = 3;
    localparam int unsigned B0_M     = 2;
    localparam int unsigned B0_R     = 1;
    localparam int unsigned B0_L     = 0;

    localparam logic [7:0] KEY_IDLE = 8'hFF;

    function automatic logic [7:0] make_key(input logic [3:0] wheel, input logic m,
                                            input logic r, input logic l);
        return {wheel, 1'b1, ~m, ~r, ~l};
    endfunction

endpackage

// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler: byte index, sync-bit check, inter-byte timeout, commit pulse.
// MOUSE_WHEEL_EN selects 4-byte IntelliMouse packets with a dz field.
module ps2_mouse_packet #(
    parameter int unsigned TIMEOUT_CYC = 16000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       commit,
    output logic       xovf,
    output logic       yovf,
    output logic       btn_m,
    output logic       btn_r,
    output logic       btn_l,
    output logic [7:0] dx,
    output logic [7:0] dy
`ifdef MOUSE_WHEEL_EN
    ,
    output logic [3:0] dz
`endif
);
    import mouse_latch_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    idx_q, idx_d, cur_idx;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          commit_q, commit_d;
    logic [4:0]    flags_q, flags_d;
    logic [7:0]    dx_q, dx_d, dy_q, dy_d;
    logic [3:0]    dz_q, dz_d;
    logic          expired;

    always_comb begin
        idx_d    = idx_q;
        cnt_d    = '0;
        commit_d = 1'b0;
        flags_d  = flags_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        dz_d     = dz_q;
        expired  = (idx_q != 2'd0) && (cnt_q >= TW'(TIMEOUT_CYC));
        // An expiring packet and a new byte in the same cycle: the byte starts a fresh packet.
        cur_idx  = expired ? 2'd0 : idx_q;
        if ((idx_q != 2'd0) && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (expired) begin
            idx_d = 2'd0;
        end
        if (rx_err) begin
            idx_d = 2'd0;
        end else if (rx_valid) begin
            cnt_d = '0;
            case (cur_idx)
                2'd0: begin
                    if (rx_data[B0_SYNC]) begin
                        flags_d = {rx_data[B0_YOVF], rx_data[B0_XOVF], rx_data[B0_M],
                                   rx_data[B0_R], rx_data[B0_L]};
                        idx_d   = 2'd1;
                    end else begin
                        idx_d = 2'd0;
                    end
                end
                2'd1: begin
                    dx_d  = rx_data;
                    idx_d = 2'd2;
                end
                2'd2: begin
                    dy_d = rx_data;
`ifdef MOUSE_WHEEL_EN
                    idx_d = 2'd3;
`else
                    idx_d    = 2'd0;
                    commit_d = 1'b1;
`endif
                end
                default: begin
`ifdef MOUSE_WHEEL_EN
                    dz_d     = rx_data[3:0];
                    commit_d = 1'b1;
`endif
                    idx_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            flags_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            dz_q     <= '0;
        end else begin
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            flags_q  <= flags_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            dz_q     <= dz_d;
        end
    end

    assign commit = commit_q;
    assign yovf   = flags_q[4];
    assign xovf   = flags_q[3];
    assign btn_m  = flags_q[2];
    assign btn_r  = flags_q[1];
    assign btn_l  = flags_q[0];
    assign dx     = dx_q;
    assign dy     = dy_q;
`ifdef MOUSE_WHEEL_EN
    assign dz     = dz_q;
`else
    logic unused_dz;
    assign unused_dz = ^dz_q;
`endif

endmodule

// File: rtl/mouse_latch_writer.sv
// Kempston mouse latch bus producer: accumulates PS/2 packets and writes X, Y, KEY with strobes.
// Define MOUSE_WHEEL_EN for IntelliMouse wheel support in KEY[7:4].
module mouse_latch_writer #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned TIMEOUT_CYC = 16000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX_VALID,
    input  logic [7:0] RX_DATA,
    input  logic       RX_ERR,
    output logic [7:0] DO,
    output logic       MX,
    output logic       MY,
    output logic       MKEY,
    output logic       BUSY
);
    import mouse_latch_pkg::*;

    localparam int unsigned CW = 16;

    logic       pk_commit, pk_xovf, pk_yovf, pk_m, pk_r, pk_l;
    logic [7:0] pk_dx, pk_dy;
    logic [3:0] pk_dz;

    ps2_mouse_packet #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_packet (
        .clk      (CLK),
        .rst_n    (RST_N),
        .rx_valid (RX_VALID),
        .rx_data  (RX_DATA),
        .rx_err   (RX_ERR),
        .commit   (pk_commit),
        .xovf     (pk_xovf),
        .yovf     (pk_yovf),
        .btn_m    (pk_m),
        .btn_r    (pk_r),
        .btn_l    (pk_l),
        .dx       (pk_dx),
        .dy       (pk_dy)
`ifdef MOUSE_WHEEL_EN
        ,
        .dz       (pk_dz)
`endif
    );
`ifndef MOUSE_WHEEL_EN
    assign pk_dz = 4'h0;
`endif

    seq_state_t    state_q, state_d;
    reg_sel_t      sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_key_q, snap_key_d;
    logic [7:0]    do_q, do_d;
    logic          mx_q, mx_d, my_q, my_d, mkey_q, mkey_d, busy_q, busy_d;
    logic          pending_q, pending_d, boot_q, boot_d;
    logic [7:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic          m_q, m_d, r_q, r_d, l_q, l_d;
    logic [3:0]    wheel_q, wheel_d;
    logic          enter_strobe;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_key_d   = snap_key_q;
        do_d         = do_q;
        mx_d         = mx_q;
        my_d         = my_q;
        mkey_d       = mkey_q;
        busy_d       = busy_q;
        pending_d    = pending_q;
        boot_d       = 1'b0;
        acc_x_d      = acc_x_q;
        acc_y_d      = acc_y_q;
        m_d          = m_q;
        r_d          = r_q;
        l_d          = l_q;
        wheel_d      = wheel_q;
        enter_strobe = 1'b0;

        if (pk_commit) begin
            if (!pk_xovf) acc_x_d = acc_x_q + pk_dx;
            if (!pk_yovf) acc_y_d = acc_y_q + pk_dy;
            m_d = pk_m;
            r_d = pk_r;
            l_d = pk_l;
`ifdef MOUSE_WHEEL_EN
            wheel_d = wheel_q + pk_dz;
`endif
        end

        // LOAD counts as the first setup cycle so each write spans exactly SETUP+STROBE+HOLD.
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d  = 1'b0;
                    snap_x_d   = acc_x_q;
                    snap_y_d   = acc_y_q;
                    snap_key_d = make_key(wheel_q, m_q, r_q, l_q);
                    sel_d      = SEL_X;
                    do_d       = acc_x_q;
                    busy_d     = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (SETUP_CYC > 1) begin
                    state_d = ST_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 2);
                end else begin
                    enter_strobe = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) enter_strobe = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    mx_d    = 1'b0;
                    my_d    = 1'b0;
                    mkey_d  = 1'b0;
                    state_d = ST_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sel_q == SEL_KEY) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    sel_d   = (sel_q == SEL_X) ? SEL_Y : SEL_KEY;
                    do_d    = (sel_q == SEL_X) ? snap_y_q : snap_key_q;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_strobe) begin
            state_d = ST_STROBE;
            cnt_d   = CW'(STROBE_CYC - 1);
            mx_d    = (sel_q == SEL_X);
            my_d    = (sel_q == SEL_Y);
            mkey_d  = (sel_q == SEL_KEY);
        end

        if (pk_commit || boot_q) pending_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_X;
            cnt_q      <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_key_q <= KEY_IDLE;
            do_q       <= 8'hFF;
            mx_q       <= 1'b0;
            my_q       <= 1'b0;
            mkey_q     <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            boot_q     <= 1'b1;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            m_q        <= 1'b0;
            r_q        <= 1'b0;
            l_q        <= 1'b0;
            wheel_q    <= 4'hF;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            snap_key_q <= snap_key_d;
            do_q       <= do_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            mkey_q     <= mkey_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            boot_q     <= boot_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            m_q        <= m_d;
            r_q        <= r_d;
            l_q        <= l_d;
            wheel_q    <= wheel_d;
        end
    end

    assign DO   = do_q;
    assign MX   = mx_q;
    assign MY   = my_q;
    assign MKEY = mkey_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_mouse_latch_writer.sv
// Self-checking bench for mouse_latch_writer; expected latch writes are queued and
// compared as strobes rise on the bus.
module tb_mouse_latch_writer;

    localparam int unsigned SETUP  = 2;
    localparam int unsigned STROBE = 4;
    localparam int unsigned HOLD   = 2;
    localparam int unsigned TMO    = 300;
`ifdef MOUSE_WHEEL_EN
    localparam int unsigned NB = 4;
`else
    localparam int unsigned NB = 3;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RX_VALID = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_ERR = 1'b0;
    logic [7:0] DO;
    logic       MX, MY, MKEY, BUSY;

    always #5 CLK = ~CLK;

    mouse_latch_writer #(
        .SETUP_CYC   (SETUP),
        .STROBE_CYC  (STROBE),
        .HOLD_CYC    (HOLD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RX_VALID (RX_VALID),
        .RX_DATA  (RX_DATA),
        .RX_ERR   (RX_ERR),
        .DO       (DO),
        .MX       (MX),
        .MY       (MY),
        .MKEY     (MKEY),
        .BUSY     (BUSY)
    );

    typedef struct {
        logic [2:0] stb;
        logic [7:0] val;
    } wr_t;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [7:0] x, y, key;
    } vec_t;

    wr_t sb[$];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [7:0] x, input logic [7:0] y, input logic [7:0] k);
        sb.push_back('{stb: 3'b001, val: x});
        sb.push_back('{stb: 3'b010, val: y});
        sb.push_back('{stb: 3'b100, val: k});
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(posedge CLK); #1;
        RX_VALID = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        if (NB == 4) send_byte(b3);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || BUSY) && n < 500) begin
            @(posedge CLK); #1;
            n++;
        end
        check({name, "_done"}, int'(n < 500), 1);
        repeat (40) @(posedge CLK);
        #1;
    endtask

    // Bus monitor: sequence order/data, one-hot strobes, setup, width and hold.
    initial begin
        logic [7:0] do_prev, do_at_rise;
        logic [2:0] stb, stb_prev;
        int         stable, width, since_fall;
        bit         fall_seen;
        wr_t        e;
        do_prev = 8'hFF; do_at_rise = 8'h00; stb_prev = 3'b000;
        stable = 0; width = 0; since_fall = 0; fall_seen = 1'b0;
        forever begin
            @(negedge CLK);
            stb = {MKEY, MY, MX};
            if (!mon_en) begin
                do_prev = DO; stb_prev = stb; fall_seen = 1'b0; stable = 1;
                continue;
            end
            if (DO !== do_prev) begin
                if (fall_seen) begin
                    tests++;
                    if (since_fall < int'(HOLD)) begin
                        fails++;
                        $display("FAIL hold: DO changed %0d cycles after strobe fell, required >= %0d",
                                 since_fall, HOLD);
                    end
                end
                fall_seen = 1'b0;
                stable = 1;
            end else begin
                stable++;
            end
            if (stb != 3'b000 && stb_prev == 3'b000) begin
                check("onehot", $countones(stb), 1);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: strobes=%b DO=%h, expected no write", stb, DO);
                end else begin
                    e = sb.pop_front();
                    check("write_reg", int'(stb), int'(e.stb));
                    check("write_data", int'(DO), int'(e.val));
                end
                tests++;
                if (stable < int'(SETUP) + 1) begin
                    fails++;
                    $display("FAIL setup: DO stable %0d cycles before strobe, required >= %0d",
                             stable - 1, SETUP);
                end
                width = 1;
                do_at_rise = DO;
            end else if (stb != 3'b000) begin
                width++;
            end
            if (stb == 3'b000 && stb_prev != 3'b000) begin
                check("strobe_width", width, int'(STROBE));
                check("do_at_fall", int'(DO), int'(do_at_rise));
                fall_seen = 1'b1;
                since_fall = 1;
            end else if (fall_seen) begin
                since_fall++;
            end
            stb_prev = stb;
            do_prev = DO;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   busy_seen;
        int   n;

        vecs[0] = '{8'h09, 8'h05, 8'h03, 8'h05, 8'h03, 8'hFE};
        vecs[1] = '{8'h18, 8'hFE, 8'h00, 8'h03, 8'h03, 8'hFF};
        vecs[2] = '{8'h48, 8'h7F, 8'h01, 8'h03, 8'h04, 8'hFF};
        vecs[3] = '{8'h08, 8'h00, 8'hFF, 8'h03, 8'h03, 8'hFF};

        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_do", int'(DO), 'hFF);
        check("reset_strobes", int'({MKEY, MY, MX}), 0);
        check("reset_busy", int'(BUSY), 0);

        push_seq(8'h00, 8'h00, 8'hFF);
        mon_en = 1'b1;
        RST_N = 1'b1;
        wait_done("init");

        for (int i = 0; i < 4; i++) begin
            push_seq(vecs[i].x, vecs[i].y, vecs[i].key);
            send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, 8'h00);
            wait_done($sformatf("vec%0d", i));
        end

        // Byte0 without the sync bit must be ignored entirely.
        send_byte(8'h00);
        busy_seen = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            busy_seen |= int'(BUSY);
        end
        check("bad_sync_busy", busy_seen, 0);

        // RX_ERR drops the partial packet.
        send_byte(8'h08);
        RX_ERR = 1'b1;
        @(posedge CLK); #1;
        RX_ERR = 1'b0;
        push_seq(8'h04, 8'h04, 8'hFF);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
        wait_done("rx_err");

        // Stale byte0 is discarded once the inter-byte timeout expires.
        send_byte(8'h08);
        repeat (TMO + 1) @(posedge CLK);
        #1;
        push_seq(8'h05, 8'h05, 8'hFF);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
        wait_done("timeout");

        // Two commits during one sequence collapse into a single follow-up.
        push_seq(8'h06, 8'h06, 8'hFE);
        send_pkt(8'h09, 8'h01, 8'h01, 8'h00);
        push_seq(8'h0B, 8'h0B, 8'hFF);
        send_pkt(8'h08, 8'h02, 8'h02, 8'h00);
        send_pkt(8'h08, 8'h03, 8'h03, 8'h00);
        wait_done("back_to_back");

`ifdef MOUSE_WHEEL_EN
        push_seq(8'h0B, 8'h0B, 8'hEF);
        send_pkt(8'h08, 8'h00, 8'h00, 8'h0F);
        wait_done("wheel");
`endif

        // Reset while a strobe is high aborts the write in the same cycle.
        push_seq(8'h0C, 8'h0C, 8'hFF);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
        n = 0;
        while (!MX && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("midwrite_reach", int'(n < 200), 1);
        @(posedge CLK); #1;
        mon_en = 1'b0;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        check("midreset_strobes", int'({MKEY, MY, MX}), 0);
        check("midreset_do", int'(DO), 'hFF);
        check("midreset_busy", int'(BUSY), 0);
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        push_seq(8'h00, 8'h00, 8'hFF);
        mon_en = 1'b1;
        RST_N = 1'b1;
        wait_done("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
